cmd_queue: RTL and testbench
============================

CMD_QUEUE -- requirements
Module: cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered command entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  a command is presented on in_kind/in_op1/in_op2 this cycle.
REQ-005 in_kind  input  3  command kind; 3'd0 = NOP.
REQ-006 in_op1  input  4  operand 1.
REQ-007 in_op2  input  8  operand 2.
REQ-008 in_ready  output  1  queue can accept a command this cycle.
REQ-009 out_valid  output  1  head entry available to the downstream command-issue stage.
REQ-010 out_kind / out_op1 / out_op2  output  3 / 4 / 8  fields of the head entry.
REQ-011 out_ready  input  1  downstream accepts the head entry this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 ovf  output  1  sticky overflow flag (see Configuration).
REQ-014 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-015 Enqueue SHALL occur when in_valid && in_ready && in_kind != 0; entry written at the write pointer.
REQ-016 NOP commands (in_kind == 0) SHALL be discarded: no enqueue, no count change, no ovf effect.
REQ-017 in_ready SHALL be 1 iff count < DEPTH; it SHALL not depend on out_ready (no pass-through when full).
REQ-018 Dequeue SHALL occur when out_valid && out_ready; the read pointer advances.
REQ-019 out_valid SHALL be 1 iff count > 0; out_* SHALL show the head entry and SHALL be 0 when empty.
REQ-020 Latency: a command enqueued at edge N SHALL appear on out_* with out_valid=1 after edge N if the queue was empty; no same-cycle bypass.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and update both pointers.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 Order SHALL be strict FIFO; entries SHALL never be duplicated or lost while in_ready was 1 at enqueue.
REQ-024 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Full and empty SHALL be derived from count, never from pointer equality alone.

Reset
REQ-026 On rst_n=0: pointers=0, count=0, out_valid=0, out_*=0, in_ready=1, ovf=0, asynchronously.
REQ-027 Reset mid-operation SHALL discard all buffered entries; storage contents need no reset but SHALL not be visible (out_* gated by out_valid).
REQ-028 First enqueue SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro CMDQ_OVF_FLAG_EN: when defined, ovf SHALL set on any edge where in_valid=1, in_kind != 0, and in_ready=0, and SHALL remain set until clr_ovf=1 or reset; clr_ovf and a new overflow on the same edge SHALL leave ovf=1.
REQ-030 When CMDQ_OVF_FLAG_EN is not defined, ovf SHALL be constant 0, clr_ovf SHALL be ignored, and no overflow register SHALL be present.

Verification
REQ-031 Reset, then enqueue kind=1/op1=3/op2=0x5A with out_ready=0 -> next cycle out_valid=1, out_kind=1, out_op1=3, out_op2=0x5A, count=1.
REQ-032 DEPTH=4: enqueue 4 commands (kinds 1..4), out_ready=0 -> count=4, in_ready=0; a fifth command (kind 5) -> rejected, ovf=1 (with CMDQ_OVF_FLAG_EN), ovf=0 (without).
REQ-033 Full queue, out_ready=1 and in_valid=1 on the same cycle -> head kind 1 dequeued, new command not accepted, count=3; next cycle kind 5 accepted, count=4.
REQ-034 Stream 10 commands with out_ready toggling 1,0,1,... -> output order identical to input order, pointers wrap twice, count returns to 0, out_*=0.
REQ-035 in_valid=1, in_kind=0 for 3 cycles on an empty queue -> out_valid stays 0, count=0, ovf unchanged.
REQ-036 Queue holding 2 entries, assert rst_n=0 between edges -> out_valid, count, ovf drop to 0 immediately; after release the first new command appears at the head.

Source files
------------

// File: rtl/cmd_queue_if.sv
// -----------------------------------------------------------------------------
// cmd_queue_if -- handshake bundle for the cmd_queue command FIFO.
//
// Parameter:
//   DEPTH    number of queue entries (sets the width of count)
//
// Signals (direction as seen by the queue, modport slave):
//   in_valid  in   command presented on in_kind/in_op1/in_op2
//   in_kind   in   command kind, 3'd0 is a NOP
//   in_op1    in   operand 1
//   in_op2    in   operand 2
//   in_ready  out  queue can accept a command
//   out_valid out  head entry available
//   out_kind  out  head entry kind   (0 when empty)
//   out_op1   out  head entry op1    (0 when empty)
//   out_op2   out  head entry op2    (0 when empty)
//   out_ready in   downstream accepts the head entry
//   count     out  number of occupied entries
//   ovf       out  sticky overflow flag
//   clr_ovf   in   synchronous clear of ovf
//
// modport master is the producer/consumer side (the bench or system).
// -----------------------------------------------------------------------------
interface cmd_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic [2:0]    in_kind;
   logic [3:0]    in_op1;
   logic [7:0]    in_op2;
   logic          in_ready;
   logic          out_valid;
   logic [2:0]    out_kind;
   logic [3:0]    out_op1;
   logic [7:0]    out_op2;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          ovf;
   logic          clr_ovf;

   modport master (
      output in_valid, in_kind, in_op1, in_op2, out_ready, clr_ovf,
      input  in_ready, out_valid, out_kind, out_op1, out_op2, count, ovf
   );

   modport slave (
      input  in_valid, in_kind, in_op1, in_op2, out_ready, clr_ovf,
      output in_ready, out_valid, out_kind, out_op1, out_op2, count, ovf
   );
endinterface

// File: rtl/cmd_queue.sv
// -----------------------------------------------------------------------------
// cmd_queue -- small command FIFO between a command source and the
// command-issue stage. NOP commands (kind 0) are dropped at the input.
//
// Parameter:
//   DEPTH  entries, power of two in 2..16 (default 4)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cmd_queue_if.slave (see rtl/cmd_queue_if.sv for the signal list)
//
// Build option:
//   CMDQ_OVF_FLAG_EN  when defined, ovf is a sticky flag set by any non-NOP
//                     command offered while the queue is full; cleared by
//                     clr_ovf (a coincident overflow wins). When undefined,
//                     ovf is tied to 0 and clr_ovf is ignored.
// -----------------------------------------------------------------------------
module cmd_queue #(
   parameter int DEPTH = 4
) (
   input logic       clk,
   input logic       rst_n,
   cmd_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] op1;
      logic [7:0] op2;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // Full/empty come from the occupancy counter; pointers alone are ambiguous
   // when they are equal.
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // in_ready is independent of out_ready: a full queue never passes a
   // command through, even when the head leaves on the same edge.
   assign push = bus.in_valid && !full && (bus.in_kind != 3'd0);
   assign pop  = !empty && bus.out_ready;

   // NOTE: state registers use non-blocking assignments so every always_ff
   // samples the pre-edge values of the others, matching real flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; stale contents are harmless
   // because every output field is gated by out_valid below.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{kind: bus.in_kind, op1: bus.in_op1, op2: bus.in_op2};
      end
   end

   assign head          = mem[rd_ptr];
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_kind  = empty ? 3'd0 : head.kind;
   assign bus.out_op1   = empty ? 4'd0 : head.op1;
   assign bus.out_op2   = empty ? 8'd0 : head.op2;
   assign bus.count     = count_q;

`ifdef CMDQ_OVF_FLAG_EN
   logic ovf_q;

   // Set has priority over clear so an overflow on the clearing edge is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (bus.in_valid && (bus.in_kind != 3'd0) && full) begin
         ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_q <= 1'b0;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_cmd_queue -- directed bench for cmd_queue with a scoreboard.
// The stimulus side pushes each command it expects the queue to accept; an
// independent monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_cmd_queue;
   localparam int DEPTH = 4;

`ifdef CMDQ_OVF_FLAG_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] op1;
      logic [7:0] op2;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   cmd_queue_if #(.DEPTH(DEPTH)) bus ();

   cmd_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   checks  = 0;
   int   errors  = 0;
   int   m_count = 0;
   int   n_push  = 0;
   int   n_pop   = 0;
   int   idx     = 0;
   logic ordy;
   exp_t sb [$];
   exp_t mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; the bench decides on its own whether the
   // command should be accepted and, if so, queues it as expected output.
   task automatic cycle(input logic v, input logic [2:0] k, input logic [3:0] o1,
                        input logic [7:0] o2, input logic rdy);
      bit acc;
      bit deq;
      bus.in_valid  = v;
      bus.in_kind   = k;
      bus.in_op1    = o1;
      bus.in_op2    = o2;
      bus.out_ready = rdy;
      acc = v && (k != 3'd0) && (m_count < DEPTH);
      deq = rdy && (m_count > 0);
      if (acc) begin
         sb.push_back('{kind: k, op1: o1, op2: o2});
         n_push++;
      end
      @(posedge clk);
      #1;
      m_count = m_count + int'(acc) - int'(deq);
      bus.in_valid  = 1'b0;
      bus.in_kind   = 3'd0;
      bus.in_op1    = 4'd0;
      bus.in_op2    = 8'd0;
      bus.out_ready = 1'b0;
   endtask

   // Monitor: a handshake visible at the falling edge completes on the next
   // rising edge, so that is where the head entry is compared.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got kind %0d, expected no output", bus.out_kind);
         end else begin
            mon_e = sb.pop_front();
            n_pop++;
            check("pop_kind", 32'(bus.out_kind), 32'(mon_e.kind));
            check("pop_op1",  32'(bus.out_op1),  32'(mon_e.op1));
            check("pop_op2",  32'(bus.out_op2),  32'(mon_e.op2));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_kind   = 3'd0;
      bus.in_op1    = 4'd0;
      bus.in_op2    = 8'd0;
      bus.out_ready = 1'b0;
      bus.clr_ovf   = 1'b0;

      // Reset state
      #12;
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_count",     32'(bus.count),     32'd0);
      check("rst_ovf",       32'(bus.ovf),       32'd0);
      check("rst_out_kind",  32'(bus.out_kind),  32'd0);
      #10 rst_n = 1'b1;

      // First command after reset, visible after one edge
      cycle(1'b1, 3'd1, 4'd3, 8'h5A, 1'b0);
      check("first_valid", 32'(bus.out_valid), 32'd1);
      check("first_kind",  32'(bus.out_kind),  32'd1);
      check("first_op1",   32'(bus.out_op1),   32'd3);
      check("first_op2",   32'(bus.out_op2),   32'h5A);
      check("first_count", 32'(bus.count),     32'd1);
      cycle(1'b0, 3'd0, 4'd0, 8'd0, 1'b1);
      check("drain1_count", 32'(bus.count),    32'd0);
      check("drain1_op2",   32'(bus.out_op2),  32'd0);

      // Fill to DEPTH, then overflow
      for (int k = 1; k <= 4; k++) cycle(1'b1, 3'(k), 4'(k), 8'(8'hA0 + k), 1'b0);
      check("full_count",    32'(bus.count),    32'd4);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_ovf",      32'(bus.ovf),      32'd0);
      cycle(1'b1, 3'd5, 4'd5, 8'hA5, 1'b0);
      check("ovf_count", 32'(bus.count),    32'd4);
      check("ovf_set",   32'(bus.ovf),      32'(OVF_ON));
      check("ovf_head",  32'(bus.out_kind), 32'd1);

      // Clear coinciding with a new overflow keeps the flag; plain clear drops it
      bus.clr_ovf = 1'b1;
      cycle(1'b1, 3'd5, 4'd5, 8'hA5, 1'b0);
      check("ovf_clr_race", 32'(bus.ovf), 32'(OVF_ON));
      cycle(1'b0, 3'd0, 4'd0, 8'd0, 1'b0);
      check("ovf_cleared", 32'(bus.ovf), 32'd0);
      bus.clr_ovf = 1'b0;

      // Full queue: dequeue and offer on the same edge, no pass-through
      cycle(1'b1, 3'd5, 4'd5, 8'hA5, 1'b1);
      check("full_deq_count",    32'(bus.count),    32'd3);
      check("full_deq_in_ready", 32'(bus.in_ready), 32'd1);
      check("full_deq_head",     32'(bus.out_kind), 32'd2);
      cycle(1'b1, 3'd5, 4'd5, 8'hA5, 1'b0);
      check("retry_count", 32'(bus.count), 32'd4);
      bus.clr_ovf = 1'b1;
      cycle(1'b0, 3'd0, 4'd0, 8'd0, 1'b0);
      bus.clr_ovf = 1'b0;
      check("ovf_cleared2", 32'(bus.ovf), 32'd0);
      repeat (4) cycle(1'b0, 3'd0, 4'd0, 8'd0, 1'b1);
      check("drain2_count", 32'(bus.count),     32'd0);
      check("drain2_valid", 32'(bus.out_valid), 32'd0);

      // Stream 10 commands with out_ready toggling
      idx = 0;
      for (int c = 0; c < 60 && (idx < 10 || m_count > 0); c++) begin
         ordy = (c % 2 == 0);
         if (idx < 10 && m_count < DEPTH) begin
            cycle(1'b1, 3'(idx % 7 + 1), 4'(idx), 8'(8'h30 + idx), ordy);
            idx++;
         end else begin
            cycle(1'b0, 3'd0, 4'd0, 8'd0, ordy);
         end
      end
      check("stream_sent",  32'(idx),           32'd10);
      check("stream_count", 32'(bus.count),     32'd0);
      check("stream_valid", 32'(bus.out_valid), 32'd0);
      check("stream_kind",  32'(bus.out_kind),  32'd0);
      check("stream_op1",   32'(bus.out_op1),   32'd0);
      check("stream_op2",   32'(bus.out_op2),   32'd0);
      check("stream_sb",    32'(sb.size()),     32'd0);

      // NOPs are discarded
      repeat (3) cycle(1'b1, 3'd0, 4'd5, 8'h55, 1'b0);
      check("nop_valid", 32'(bus.out_valid), 32'd0);
      check("nop_count", 32'(bus.count),     32'd0);
      check("nop_ovf",   32'(bus.ovf),       32'd0);

      // Reset between edges with two entries held
      cycle(1'b1, 3'd6, 4'd1, 8'h11, 1'b0);
      cycle(1'b1, 3'd7, 4'd2, 8'h22, 1'b0);
      check("pre_rst_count", 32'(bus.count),    32'd2);
      check("pre_rst_head",  32'(bus.out_kind), 32'd6);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
      check("mid_rst_count",    32'(bus.count),     32'd0);
      check("mid_rst_ovf",      32'(bus.ovf),       32'd0);
      check("mid_rst_kind",     32'(bus.out_kind),  32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
      n_push  = n_push - sb.size();
      sb.delete();
      m_count = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      cycle(1'b1, 3'd2, 4'd9, 8'hC3, 1'b0);
      check("post_rst_kind",  32'(bus.out_kind), 32'd2);
      check("post_rst_op1",   32'(bus.out_op1),  32'd9);
      check("post_rst_op2",   32'(bus.out_op2),  32'hC3);
      check("post_rst_count", 32'(bus.count),    32'd1);
      cycle(1'b0, 3'd0, 4'd0, 8'd0, 1'b1);
      check("final_count", 32'(bus.count), 32'd0);
      check("pop_total",   32'(n_pop),     32'(n_push));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
